snake_step_ctrl: RTL

- Game-step sequencer for the snake datapath.
- Divides the frame `tick` into move steps, then pulses the body mover and waits for it to finish.
- Samples the head/apple collision result (`eat_evt`) plus wall and self hits, then commands grow, apple respawn (with retry on bad placement), score and game-over.
- Sits between the tick generator and the body, apple and collision blocks.

---
 rtl/snake_pkg.sv | 25 ++
 rtl/step_divider.sv | 69 ++++++
 rtl/snake_step_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: shared definitions for the snake game datapath.
//   state_t      - game-step sequencer states
//   SCORE_W_DEF  - default score counter width
//   CELL         - playfield cell size in pixels (collision and apple blocks)
//   cw()         - counter width helper, never returns less than 1
package snake_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        WAIT_BODY,
        CHECK,
        RESPAWN,
        OVER
    } state_t;

    localparam int SCORE_W_DEF = 8;
    localparam int CELL        = 16;

    // Bits needed to hold values 0..v-1 (minimum 1 bit).
    function automatic int cw(input int v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/step_divider.sv
// step_divider: divides frame ticks into move steps.
// Optional feature macro: SNAKE_SPEEDUP_EN. When defined, the period shrinks
// by one for every 8 points of score (never below 1). The period is only
// re-sampled while hold=0, so it is frozen for the whole WAIT_TICK phase.
// When undefined, the period is the constant TICK_DIV.
// Ports:
//   clk     in   pixel clock
//   reset   in   synchronous, active-high
//   clr     in   clear the tick counter (game restart)
//   tick_en in   frame tick qualified by the WAIT_TICK state
//   hold    in   1 while in WAIT_TICK; freezes the period
//   score   in   current score (speed-up input)
//   step    out  combinational: this tick completes a period
module step_divider
    import snake_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int SCORE_W  = SCORE_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               tick_en,
    input  logic               hold,
    input  logic [SCORE_W-1:0] score,
    output logic               step
);

    localparam int CW = cw(TICK_DIV + 1);

    logic [CW-1:0] div_cnt;
    logic [CW-1:0] period;

`ifdef SNAKE_SPEEDUP_EN
    logic [SCORE_W-1:0] level;
    logic [CW-1:0]      period_calc;

    assign level = score >> 3;

    always_comb begin
        period_calc = CW'(1);
        if (int'(level) < TICK_DIV - 1)
            period_calc = CW'(TICK_DIV - int'(level));
    end

    always_ff @(posedge clk) begin
        if (reset)
            period <= CW'(TICK_DIV);
        else if (!hold)
            period <= period_calc;
    end
`else
    logic unused_speed;
    assign unused_speed = ^{hold, score};
    assign period       = CW'(TICK_DIV);
`endif

    // >= rather than == keeps the counter safe if the period ever shrinks
    // below a stale count.
    assign step = tick_en && ((div_cnt + CW'(1)) >= period);

    always_ff @(posedge clk) begin
        if (reset || clr)
            div_cnt <= '0;
        else if (tick_en)
            div_cnt <= step ? '0 : div_cnt + CW'(1);
    end

endmodule

// File: rtl/snake_step_ctrl.sv
// snake_step_ctrl: game-step sequencer for the snake datapath.
// Divides frame ticks into move steps, pulses the body mover, waits for it
// (with a watchdog), evaluates wall/self/apple results, and drives grow,
// apple respawn (with bounded retries), score and game over.
// Optional feature macro: SNAKE_SPEEDUP_EN (handled in step_divider).
// Ports:
//   clk_pix        in   pixel clock
//   reset          in   synchronous, active-high
//   tick           in   one-cycle frame pulse
//   start_btn      in   level, start/restart
//   body_done      in   pulse, body shift complete
//   eat_evt        in   pulse, head on apple
//   wall_hit       in   level, head outside playfield
//   self_hit       in   level, head on body
//   apple_ack      in   pulse, apple placement finished
//   apple_on_snake in   level, valid with apple_ack
//   move_stb       out  pulse, advance body one cell
//   grow           out  pulse, lengthen body
//   apple_req      out  level, request apple placement
//   score          out  apples eaten (saturating)
//   running        out  game active
//   game_over      out  sticky until restart
module snake_step_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_DIV  = 4,
    parameter int SCORE_W   = SCORE_W_DEF,
    parameter int MAX_RETRY = 3,
    parameter int BODY_TO   = 1023
) (
    input  logic               clk_pix,
    input  logic               reset,
    input  logic               tick,
    input  logic               start_btn,
    input  logic               body_done,
    input  logic               eat_evt,
    input  logic               wall_hit,
    input  logic               self_hit,
    input  logic               apple_ack,
    input  logic               apple_on_snake,
    output logic               move_stb,
    output logic               grow,
    output logic               apple_req,
    output logic [SCORE_W-1:0] score,
    output logic               running,
    output logic               game_over
);

    localparam int WW = cw(BODY_TO);
    localparam int RW = cw(MAX_RETRY + 1);

    state_t        state;
    logic [WW-1:0] wd_cnt;
    logic [RW-1:0] retry_cnt;
    logic          eat_seen;
    logic          step;
    logic          restart;

    assign restart = start_btn && (state == IDLE || state == OVER);

    step_divider #(
        .TICK_DIV (TICK_DIV),
        .SCORE_W  (SCORE_W)
    ) u_div (
        .clk     (clk_pix),
        .reset   (reset),
        .clr     (restart),
        .tick_en (tick && state == WAIT_TICK),
        .hold    (state == WAIT_TICK),
        .score   (score),
        .step    (step)
    );

    always_ff @(posedge clk_pix) begin
        if (reset) begin
            state     <= IDLE;
            move_stb  <= 1'b0;
            grow      <= 1'b0;
            apple_req <= 1'b0;
            score     <= '0;
            running   <= 1'b0;
            game_over <= 1'b0;
            wd_cnt    <= '0;
            retry_cnt <= '0;
            eat_seen  <= 1'b0;
        end else begin
            move_stb <= 1'b0;
            grow     <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    if (start_btn) begin
                        game_over <= 1'b0;
                        running   <= 1'b1;
                        score     <= '0;
                        apple_req <= 1'b1;
                        retry_cnt <= '0;
                        eat_seen  <= 1'b0;
                        state     <= RESPAWN;
                    end
                end
                WAIT_TICK: begin
                    if (step) begin
                        move_stb <= 1'b1;
                        wd_cnt   <= '0;
                        state    <= WAIT_BODY;
                    end
                end
                WAIT_BODY: begin
                    if (eat_evt)
                        eat_seen <= 1'b1;
                    if (body_done) begin
                        state <= CHECK;
                    end else if (wd_cnt == WW'(BODY_TO - 1)) begin
                        // Body mover never answered: treat as fatal.
                        running   <= 1'b0;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        wd_cnt <= wd_cnt + WW'(1);
                    end
                end
                CHECK: begin
                    // Collision outranks eating in the same step.
                    if (wall_hit || self_hit) begin
                        running   <= 1'b0;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else if (eat_seen || eat_evt) begin
                        grow      <= 1'b1;
                        if (~&score)
                            score <= score + 1'b1;
                        apple_req <= 1'b1;
                        state     <= RESPAWN;
                    end else begin
                        eat_seen <= 1'b0;
                        state    <= WAIT_TICK;
                    end
                end
                RESPAWN: begin
                    // A rejected placement drops apple_req for one cycle so
                    // each retry is a fresh request edge.
                    if (apple_req && apple_ack) begin
                        apple_req <= 1'b0;
                        if (apple_on_snake && retry_cnt < RW'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + RW'(1);
                        end else begin
                            retry_cnt <= '0;
                            eat_seen  <= 1'b0;
                            state     <= WAIT_TICK;
                        end
                    end else if (!apple_req) begin
                        apple_req <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
